// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD bus arbiter: FSM encoding, word layout and
// fixed client slots.
package lcd_pkg;

  localparam int LCD_DATA_W = 9;
  localparam int LCD_DC_BIT = 8;

  localparam int REQ_INIT = 0;
  localparam int REQ_CHAR = 1;
  localparam int REQ_FILL = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RELEASE   = 2'd3
  } arb_state_t;

  function automatic logic is_data_word(input logic [LCD_DATA_W-1:0] w);
    return w[LCD_DC_BIT];
  endfunction

endpackage

// File: rtl/lcd_rr_pick.sv
// Combinational round-robin picker: lowest eligible index at or above rr_ptr,
// wrapping to the lowest eligible index overall.
module lcd_rr_pick
  import lcd_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  elig_i,
  input  logic [PW-1:0] rr_ptr_i,
  output logic [N-1:0]  win_o,
  output logic          any_o
);

  logic [N-1:0] upper_mask;
  logic [N-1:0] upper;
  logic [N-1:0] pool;

  always_comb begin
    upper_mask = ~((N'(1) << rr_ptr_i) - N'(1));
    upper      = elig_i & upper_mask;
    pool       = (upper != '0) ? upper : elig_i;
    // isolate the lowest set bit of the candidate pool
    win_o      = pool & (~pool + N'(1));
    any_o      = |elig_i;
  end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Burst arbiter in front of the single lcd_write SPI engine: owns the bus per
// burst, forwards one word at a time and returns word-complete to the owner.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = LCD_DATA_W,
  parameter int TIMEOUT = 1000000
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic                      init_done,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        wr_en,
  input  logic [NUM_REQ*DATA_W-1:0] wr_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        wr_done_o,
  output logic [DATA_W-1:0]         lcd_data,
  output logic                      lcd_en_write,
  input  logic                      lcd_wr_done,
  output logic                      busy,
  output logic                      timeout_flag,
  output logic                      drop_err
);

  localparam int            PW      = $clog2(NUM_REQ);
  localparam int            WW      = $clog2(TIMEOUT);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  arb_state_t          state_q,   state_d;
  logic [PW-1:0]       rr_ptr_q,  rr_ptr_d;
  logic [PW-1:0]       owner_q,   owner_d;
  logic [WW-1:0]       wd_cnt_q,  wd_cnt_d;
  logic [NUM_REQ-1:0]  gnt_q,     gnt_d;
  logic [NUM_REQ-1:0]  done_q,    done_d;
  logic [DATA_W-1:0]   data_q,    data_d;
  logic                en_q,      en_d;
  logic                drop_q,    drop_d;

  logic [NUM_REQ-1:0]  elig;
  logic [NUM_REQ-1:0]  win;
  logic                win_any;
  logic [PW-1:0]       win_idx;
  logic [DATA_W-1:0]   own_word;
  logic [NUM_REQ-1:0]  keep_mask;
  logic                own_wr;
  logic                own_req;
  logic                wd_expire;

  assign elig = req & (init_done ? {NUM_REQ{1'b1}} : (NUM_REQ'(1) << REQ_INIT));

  lcd_rr_pick #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_pick (
    .elig_i   (elig),
    .rr_ptr_i (rr_ptr_q),
    .win_o    (win),
    .any_o    (win_any)
  );

  always_comb begin
    win_idx  = '0;
    own_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i])   win_idx  = PW'(i);
      if (gnt_q[i]) own_word = own_word | wr_data[i*DATA_W +: DATA_W];
    end
  end

  // gnt_q is one-hot on the owner throughout GRANT and WAIT_DONE
  assign own_wr    = |(wr_en & gnt_q);
  assign own_req   = |(req & gnt_q);
  assign wd_expire = (state_q == ST_GRANT) && !own_wr && own_req && (wd_cnt_q == WD_LAST);
  assign keep_mask = (state_q == ST_GRANT) ? gnt_q : '0;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    wd_cnt_d = wd_cnt_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    data_d   = data_q;
    en_d     = 1'b0;
    drop_d   = |(wr_en & ~keep_mask);

    unique case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          gnt_d   = win;
          owner_d = win_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (own_wr) begin
          data_d   = own_word;
          en_d     = 1'b1;
          wd_cnt_d = '0;
          state_d  = ST_WAIT_DONE;
        end else if (!own_req || wd_expire) begin
          gnt_d   = '0;
          state_d = ST_RELEASE;
        end else if (wd_cnt_q != '1) begin
          wd_cnt_d = wd_cnt_q + WW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (lcd_wr_done) begin
          done_d = gnt_q;
          if (!own_req) begin
            gnt_d   = '0;
            state_d = ST_RELEASE;
          end else begin
            state_d = ST_GRANT;
          end
        end
      end
      ST_RELEASE: begin
        rr_ptr_d = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);
        wd_cnt_d = '0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      wd_cnt_q <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      data_q   <= '0;
      en_q     <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      wd_cnt_q <= wd_cnt_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      data_q   <= data_d;
      en_q     <= en_d;
      drop_q   <= drop_d;
    end
  end

  assign gnt          = gnt_q;
  assign wr_done_o    = done_q;
  assign lcd_data     = data_q;
  assign lcd_en_write = en_q;
  assign busy         = (state_q == ST_WAIT_DONE);
  // Mealy pulse so the flag lands in the last GRANT cycle, ahead of the gnt drop
  assign timeout_flag = wd_expire;
  assign drop_err     = drop_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Scoreboard bench for lcd_bus_arbiter with a 16-cycle lcd_write model.
module tb_lcd_bus_arbiter;
  import lcd_pkg::*;

  localparam int N  = 3;
  localparam int W  = LCD_DATA_W;
  localparam int DONE_LAT = 16;

  logic           sys_clk, sys_rst, init_done, lcd_wr_done;
  logic [N-1:0]   req, wr_en, gnt, wr_done_o;
  logic [N*W-1:0] wr_data;
  logic [W-1:0]   lcd_data;
  logic           lcd_en_write, busy, timeout_flag, drop_err;

  int n_checks = 0, n_fail = 0;
  int en_cnt = 0, drop_cnt = 0, tmo_cnt = 0, unstable = 0, wcnt = 0;
  logic [W-1:0] last_word;
  logic [W-1:0] exp_word[$], obs_word[$];
  logic [N-1:0] exp_done[$], obs_done[$];

  lcd_bus_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_done(init_done), .req(req),
    .wr_en(wr_en), .wr_data(wr_data), .gnt(gnt), .wr_done_o(wr_done_o),
    .lcd_data(lcd_data), .lcd_en_write(lcd_en_write), .lcd_wr_done(lcd_wr_done),
    .busy(busy), .timeout_flag(timeout_flag), .drop_err(drop_err));

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // One clock step: observe outputs after the edge, then run the lcd_write model.
  task automatic cyc();
    @(posedge sys_clk); #1;
    if (lcd_en_write) begin
      en_cnt++;
      obs_word.push_back(lcd_data);
      last_word = lcd_data;
    end else if (wcnt != 0 && lcd_data !== last_word) unstable++;
    if (wr_done_o != '0) obs_done.push_back(wr_done_o);
    if (drop_err) drop_cnt++;
    if (timeout_flag) tmo_cnt++;
    lcd_wr_done = 1'b0;
    if (sys_rst) wcnt = 0;
    else if (lcd_en_write) wcnt = DONE_LAT;
    else if (wcnt != 0) begin
      wcnt--;
      if (wcnt == 0) lcd_wr_done = 1'b1;
    end
  endtask

  task automatic strobe(input int c, input logic [W-1:0] w, input bit sent);
    wr_en = '0;
    wr_en[c] = 1'b1;
    wr_data[c*W +: W] = w;
    if (sent) begin
      exp_word.push_back(w);
      exp_done.push_back(N'(1) << c);
    end
    cyc();
    wr_en = '0;
  endtask

  task automatic wait_done(output bit ok);
    int n0 = obs_done.size();
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      cyc();
      if (obs_done.size() > n0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_gnt(output bit ok, output int gap);
    ok = 1'b0;
    gap = 0;
    for (int i = 0; i < 64; i++) begin
      if (gnt != '0) begin ok = 1'b1; break; end
      gap++;
      cyc();
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1; req = '0; wr_en = '0; init_done = 1'b0;
    cyc(); cyc();
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; init_done = 1'b0; req = '0; wr_en = '0; wr_data = '0; lcd_wr_done = 1'b0;
    cyc(); cyc(); cyc();
    n_checks++; if (gnt !== '0 || wr_done_o !== '0) begin n_fail++; $display("FAIL reset_gnt: gnt=%b done=%b want 0", gnt, wr_done_o); end
    n_checks++; if (lcd_data !== '0 || lcd_en_write !== 1'b0) begin n_fail++; $display("FAIL reset_lcd: data=%h en=%b want 0", lcd_data, lcd_en_write); end
    n_checks++; if ({busy, timeout_flag, drop_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {busy, timeout_flag, drop_err}); end
    sys_rst = 1'b0;
  endtask

  task automatic test_init_gating();
    int bad = 0;
    init_done = 1'b0; req = 3'b110;
    for (int i = 0; i < 50; i++) begin cyc(); if (gnt !== '0) bad++; end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL t1_gated: %0d granted cycles, want 0", bad); end
    req = 3'b111;
    cyc();
    n_checks++; if (gnt !== 3'b001) begin n_fail++; $display("FAIL t1_init_gnt: got %b want 001", gnt); end
    req = '0;
    cyc(); cyc();
  endtask

  task automatic test_burst();
    logic [W-1:0] words [3] = '{9'h02A, 9'h100, 9'h17F};
    logic [W-1:0] e, o;
    bit ok;
    init_done = 1'b1; req = N'(1) << REQ_CHAR;
    cyc();
    n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL t2_gnt: got %b want 010", gnt); end
    for (int k = 0; k < 3; k++) begin
      strobe(REQ_CHAR, words[k], 1'b1);
      n_checks++; if (!(busy === 1'b1 && lcd_en_write === 1'b1)) begin n_fail++; $display("FAIL t2_issue%0d: busy=%b en=%b want 1 1", k, busy, lcd_en_write); end
      wait_done(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL t2_done%0d: no wr_done_o within bound", k); end
      n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL t2_hold%0d: got %b want 010", k, gnt); end
    end
    req = '0;
    cyc();
    n_checks++; if (gnt !== '0) begin n_fail++; $display("FAIL t2_release: got %b want 000", gnt); end
    cyc();
    n_checks++; if (unstable != 0) begin n_fail++; $display("FAIL t2_stable: %0d changes in flight, want 0", unstable); end
    while (exp_word.size() > 0) begin
      e = exp_word.pop_front();
      o = (obs_word.size() > 0) ? obs_word.pop_front() : 'x;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL t2_word: got %h want %h", o, e); end
    end
    while (exp_done.size() > 0) begin
      e = W'(exp_done.pop_front());
      o = (obs_done.size() > 0) ? W'(obs_done.pop_front()) : 'x;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL t2_done_route: got %b want %b", o, e); end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] order [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    logic [W-1:0] e, o;
    bit ok;
    int gap, idx;
    do_reset();
    init_done = 1'b1; req = 3'b111;
    for (int b = 0; b < 5; b++) begin
      wait_gnt(ok, gap);
      n_checks++; if (gnt !== order[b]) begin n_fail++; $display("FAIL t3_order%0d: got %b want %b", b, gnt, order[b]); end
      if (b > 0) begin
        n_checks++; if (gap != 2) begin n_fail++; $display("FAIL t3_gap%0d: got %0d want 2", b, gap); end
      end
      idx = (gnt[2]) ? 2 : (gnt[1] ? 1 : 0);
      req[idx] = 1'b0;
      strobe(idx, W'(9'h140 + b), 1'b1);
      wait_done(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL t3_done%0d: no wr_done_o within bound", b); end
      req[idx] = 1'b1;
    end
    req = '0;
    cyc(); cyc(); cyc();
    while (exp_word.size() > 0) begin
      e = exp_word.pop_front();
      o = (obs_word.size() > 0) ? obs_word.pop_front() : 'x;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL t3_word: got %h want %h", o, e); end
    end
    while (exp_done.size() > 0) begin
      e = W'(exp_done.pop_front());
      o = (obs_done.size() > 0) ? W'(obs_done.pop_front()) : 'x;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL t3_done_route: got %b want %b", o, e); end
    end
  endtask

  task automatic test_watchdog();
    bit ok;
    int gap, t0;
    do_reset();
    init_done = 1'b1; req = N'(1) << REQ_FILL;
    wait_gnt(ok, gap);
    n_checks++; if (gnt !== 3'b100) begin n_fail++; $display("FAIL t4_gnt: got %b want 100", gnt); end
    req = 3'b110;
    t0 = tmo_cnt;
    for (int k = 1; k <= 8; k++) begin
      n_checks++; if (timeout_flag !== (k == 8)) begin n_fail++; $display("FAIL t4_flag_c%0d: got %b want %b", k, timeout_flag, (k == 8)); end
      cyc();
    end
    n_checks++; if (gnt !== '0) begin n_fail++; $display("FAIL t4_revoke: got %b want 000", gnt); end
    n_checks++; if (tmo_cnt - t0 != 1) begin n_fail++; $display("FAIL t4_pulses: got %0d want 1", tmo_cnt - t0); end
    cyc();
    n_checks++; if (gnt !== '0) begin n_fail++; $display("FAIL t4_gap: got %b want 000", gnt); end
    cyc();
    n_checks++; if (gnt !== 3'b010) begin n_fail++; $display("FAIL t4_next: got %b want 010", gnt); end
    req = '0;
    cyc(); cyc();
  endtask

  task automatic test_protocol_errors();
    logic [W-1:0] e, o;
    bit ok;
    int d0, e0, n0;
    do_reset();
    init_done = 1'b1; req = 3'b010;
    cyc();
    d0 = drop_cnt; e0 = en_cnt;
    strobe(REQ_INIT, 9'h0AA, 1'b0);
    n_checks++; if (!(gnt === 3'b010 && busy === 1'b0 && drop_err === 1'b1)) begin n_fail++; $display("FAIL t5_foreign: gnt=%b busy=%b drop=%b want 010 0 1", gnt, busy, drop_err); end
    strobe(REQ_CHAR, 9'h1C3, 1'b1);
    cyc();
    strobe(REQ_CHAR, 9'h0FF, 1'b0);
    cyc();
    strobe(REQ_CHAR, 9'h011, 1'b0);
    wait_done(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL t5_done: no wr_done_o within bound"); end
    n_checks++; if (drop_cnt - d0 != 3) begin n_fail++; $display("FAIL t5_drops: got %0d want 3", drop_cnt - d0); end
    n_checks++; if (en_cnt - e0 != 1) begin n_fail++; $display("FAIL t5_sends: got %0d want 1", en_cnt - e0); end
    n0 = obs_done.size();
    lcd_wr_done = 1'b1;
    cyc();
    n_checks++; if (!(obs_done.size() == n0 && gnt === 3'b010 && busy === 1'b0)) begin n_fail++; $display("FAIL t5_spurious: dones=%0d gnt=%b busy=%b want %0d 010 0", obs_done.size(), gnt, busy, n0); end
    req = '0;
    cyc(); cyc();
    while (exp_word.size() > 0) begin
      e = exp_word.pop_front();
      o = (obs_word.size() > 0) ? obs_word.pop_front() : 'x;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL t5_word: got %h want %h", o, e); end
    end
    n_checks++; if (obs_word.size() != 0) begin n_fail++; $display("FAIL t5_extra_words: got %0d want 0", obs_word.size()); end
    while (exp_done.size() > 0) begin
      e = W'(exp_done.pop_front());
      o = (obs_done.size() > 0) ? W'(obs_done.pop_front()) : 'x;
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL t5_done_route: got %b want %b", o, e); end
    end
  endtask

  task automatic test_reset_mid_word();
    int n0;
    do_reset();
    init_done = 1'b1; req = 3'b010;
    cyc();
    strobe(REQ_CHAR, 9'h155, 1'b1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL t6_busy: got %b want 1", busy); end
    sys_rst = 1'b1;
    cyc();
    n_checks++; if ({gnt, wr_done_o, lcd_data} !== '0) begin n_fail++; $display("FAIL t6_rst_bus: gnt=%b done=%b data=%h want 0", gnt, wr_done_o, lcd_data); end
    n_checks++; if ({lcd_en_write, busy, timeout_flag, drop_err} !== 4'b0) begin n_fail++; $display("FAIL t6_rst_flags: got %b want 0000", {lcd_en_write, busy, timeout_flag, drop_err}); end
    sys_rst = 1'b0; req = '0;
    exp_done.delete(); exp_word.delete(); obs_word.delete();
    cyc(); cyc();
    n0 = obs_done.size();
    lcd_wr_done = 1'b1;
    cyc();
    n_checks++; if (!(obs_done.size() == n0 && gnt === '0 && busy === 1'b0)) begin n_fail++; $display("FAIL t6_late_done: dones=%0d gnt=%b busy=%b want %0d 000 0", obs_done.size(), gnt, busy, n0); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_init_gating();
    test_burst();
    test_round_robin();
    test_watchdog();
    test_protocol_errors();
    test_reset_mid_word();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
